// File: rtl/usb_utmi_tx_buf.sv
// UTMI transmit buffer: byte FIFO between the SIE and a UTMI PHY, with
// threshold/packet-end start, optional 16-bit packing and underrun flushing.
module usb_utmi_tx_buf #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned START_LVL = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        utmi_data_in,
  output logic                     utmi_tx_valid,
  output logic                     utmi_tx_validh,
  input  logic                     utmi_tx_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     underrun
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam bit          WIDE = (DATA_W == 16);

  typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [8:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [LW-1:0]   last_cnt_q, last_cnt_d;
  logic            in_ready_q;
  logic            underrun_q, underrun_d;
  logic            push;
  logic            last_pop;
  logic [1:0]      pop_n;
  logic [8:0]      head, head2;
  logic            validh_c;

  assign push     = in_valid & in_ready_q;
  assign head     = mem_q[rd_ptr_q];
  assign head2    = mem_q[rd_ptr_q + AW'(1)];
  // A second byte may only ride along if the head byte does not end the packet.
  assign validh_c = WIDE && (state_q == SEND) && !head[8] && (level_q >= LW'(2));

  assign in_ready       = in_ready_q;
  assign utmi_tx_valid  = (state_q == SEND);
  assign utmi_tx_validh = validh_c;
  assign level          = level_q;
  assign busy           = (state_q != IDLE);
  assign underrun       = underrun_q;

  always_comb begin
    utmi_data_in = '0;
    if (state_q == SEND) begin
      utmi_data_in[7:0] = head[7:0];
      if (validh_c) utmi_data_in[DATA_W-1 -: 8] = head2[7:0];
    end
  end

  // Next-state, pop count and underrun detection.
  always_comb begin
    state_d    = state_q;
    pop_n      = 2'd0;
    last_pop   = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if ((last_cnt_q != '0) || (level_q >= LW'(START_LVL))) state_d = SEND;
      end
      SEND: begin
        if ((level_q == '0) || (WIDE && (level_q == LW'(1)) && !head[8])) begin
          underrun_d = 1'b1;
          state_d    = FLUSH;
        end else if (utmi_tx_ready) begin
          pop_n = validh_c ? 2'd2 : 2'd1;
          if (validh_c ? head2[8] : head[8]) begin
            last_pop = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      FLUSH: begin
        if (level_q != '0) begin
          pop_n = 2'd1;
          if (head[8]) begin
            last_pop = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_d    = level_q + LW'(push) - LW'(pop_n);
  assign last_cnt_d = last_cnt_q + LW'(push & in_last) - LW'(last_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      last_cnt_q <= '0;
      in_ready_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q   <= rd_ptr_q + AW'(pop_n);
      level_q    <= level_d;
      last_cnt_q <= last_cnt_d;
      in_ready_q <= (level_d != LW'(DEPTH));
      underrun_q <= underrun_d;
    end
  end

  // Storage needs no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

endmodule

// File: tb/tb_usb_utmi_tx_buf.sv
// Directed bench for usb_utmi_tx_buf: an 8-bit and a 16-bit instance driven
// from one linear sequence with hand-computed expectations.
module tb_usb_utmi_tx_buf;

  logic        clk;
  logic        rst_n;

  logic [7:0]  a_data;
  logic        a_last, a_valid, a_ready, a_txv, a_txvh, a_txr, a_busy, a_unr;
  logic [7:0]  a_out;
  logic [4:0]  a_lvl;

  logic [7:0]  b_data;
  logic        b_last, b_valid, b_ready, b_txv, b_txvh, b_txr, b_busy, b_unr;
  logic [15:0] b_out;
  logic [4:0]  b_lvl;

  int passed = 0;
  int total  = 0;

  usb_utmi_tx_buf #(.DATA_W(8), .DEPTH(16), .START_LVL(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_data), .in_last(a_last), .in_valid(a_valid), .in_ready(a_ready),
    .utmi_data_in(a_out), .utmi_tx_valid(a_txv), .utmi_tx_validh(a_txvh),
    .utmi_tx_ready(a_txr), .level(a_lvl), .busy(a_busy), .underrun(a_unr)
  );

  usb_utmi_tx_buf #(.DATA_W(16), .DEPTH(16), .START_LVL(8)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_data), .in_last(b_last), .in_valid(b_valid), .in_ready(b_ready),
    .utmi_data_in(b_out), .utmi_tx_valid(b_txv), .utmi_tx_validh(b_txvh),
    .utmi_tx_ready(b_txr), .level(b_lvl), .busy(b_busy), .underrun(b_unr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit wide, input logic [7:0] d, input logic l);
    if (wide) begin
      b_data = d; b_last = l; b_valid = 1'b1;
    end else begin
      a_data = d; a_last = l; a_valid = 1'b1;
    end
    @(posedge clk); #1;
    a_valid = 1'b0; a_last = 1'b0;
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_data = '0; a_last = 1'b0; a_valid = 1'b0; a_txr = 1'b0;
    b_data = '0; b_last = 1'b0; b_valid = 1'b0; b_txr = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(a_ready), 32'd0);
    chk("rst_txv",      32'(a_txv),   32'd0);
    chk("rst_level",    32'(a_lvl),   32'd0);
    chk("rst_busy",     32'(a_busy),  32'd0);
    chk("rst_data",     32'(a_out),   32'd0);
    chk("rst_txvh16",   32'(b_txvh),  32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready8",  32'(a_ready), 32'd1);
    chk("post_rst_in_ready16", 32'(b_ready), 32'd1);

    // Three-byte packet, 8-bit
    a_txr = 1'b1;
    push(1'b0, 8'hA1, 1'b0);
    push(1'b0, 8'hB2, 1'b0);
    push(1'b0, 8'hC3, 1'b1);
    @(negedge clk);
    chk("p3_idle_txv", 32'(a_txv), 32'd0);
    chk("p3_level",    32'(a_lvl), 32'd3);
    @(negedge clk);
    chk("p3_txv0", 32'(a_txv), 32'd1);
    chk("p3_b0",   32'(a_out), 32'hA1);
    @(negedge clk);
    chk("p3_b1",   32'(a_out), 32'hB2);
    @(negedge clk);
    chk("p3_b2",   32'(a_out), 32'hC3);
    chk("p3_txv2", 32'(a_txv), 32'd1);
    @(negedge clk);
    chk("p3_end_txv",   32'(a_txv),  32'd0);
    chk("p3_end_level", 32'(a_lvl),  32'd0);
    chk("p3_end_busy",  32'(a_busy), 32'd0);

    // Five-byte packet, 16-bit
    b_txr = 1'b1;
    push(1'b1, 8'h01, 1'b0);
    push(1'b1, 8'h02, 1'b0);
    push(1'b1, 8'h03, 1'b0);
    push(1'b1, 8'h04, 1'b0);
    push(1'b1, 8'h05, 1'b1);
    @(negedge clk);
    chk("w_idle_txv", 32'(b_txv), 32'd0);
    @(negedge clk);
    chk("w0_data",  32'(b_out),  32'h0201);
    chk("w0_txvh",  32'(b_txvh), 32'd1);
    @(negedge clk);
    chk("w1_data",  32'(b_out),  32'h0403);
    chk("w1_txvh",  32'(b_txvh), 32'd1);
    @(negedge clk);
    chk("w2_lo",    32'(b_out[7:0]), 32'h05);
    chk("w2_txvh",  32'(b_txvh), 32'd0);
    chk("w2_txv",   32'(b_txv),  32'd1);
    @(negedge clk);
    chk("w_end_txv",   32'(b_txv), 32'd0);
    chk("w_end_level", 32'(b_lvl), 32'd0);
    chk("w_end_unr",   32'(b_unr), 32'd0);
    b_txr = 1'b0;

    // Fill to full with the PHY stalled, then a refused push alongside a pop
    a_txr = 1'b0;
    for (int i = 0; i < 16; i++) push(1'b0, 8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    chk("full_level",    32'(a_lvl),   32'd16);
    chk("full_in_ready", 32'(a_ready), 32'd0);
    chk("full_txv",      32'(a_txv),   32'd1);
    chk("full_data",     32'(a_out),   32'h10);
    a_data = 8'hEE; a_last = 1'b1; a_valid = 1'b1; a_txr = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; a_last = 1'b0; a_txr = 1'b0;
    @(negedge clk);
    chk("full_pop_level",    32'(a_lvl),   32'd15);
    chk("full_pop_data",     32'(a_out),   32'h11);
    chk("full_pop_in_ready", 32'(a_ready), 32'd1);

    // Toggled TXReady: data held while stalled, every byte seen once in order
    for (int i = 0; i < 15; i++) begin
      a_txr = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("toggle_hold", 32'(a_out), 32'h11 + 32'(i));
      a_txr = 1'b1;
      @(posedge clk); #1;
      a_txr = 1'b0;
      @(negedge clk);
    end
    chk("toggle_drained", 32'(a_lvl), 32'd0);
    push(1'b0, 8'h99, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("toggle_recover_busy",  32'(a_busy), 32'd0);
    chk("toggle_recover_level", 32'(a_lvl),  32'd0);

    // Threshold start followed by starvation
    a_txr = 1'b1;
    for (int i = 0; i < 8; i++) push(1'b0, 8'h30 + 8'(i), 1'b0);
    @(negedge clk);
    chk("thr_idle_txv", 32'(a_txv), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("thr_txv",  32'(a_txv), 32'd1);
      chk("thr_data", 32'(a_out), 32'h30 + 32'(i));
    end
    @(negedge clk);
    chk("thr_empty_level", 32'(a_lvl), 32'd0);
    chk("thr_empty_unr",   32'(a_unr), 32'd0);
    @(negedge clk);
    chk("unr_pulse",   32'(a_unr),  32'd1);
    chk("unr_txv",     32'(a_txv),  32'd0);
    chk("unr_busy",    32'(a_busy), 32'd1);
    @(negedge clk);
    chk("unr_once",    32'(a_unr),  32'd0);
    push(1'b0, 8'h40, 1'b0);
    @(negedge clk);
    chk("flush_txv0",  32'(a_txv),  32'd0);
    push(1'b0, 8'h41, 1'b1);
    @(negedge clk);
    chk("flush_txv1",  32'(a_txv),  32'd0);
    @(negedge clk);
    chk("flush_done_busy",  32'(a_busy), 32'd0);
    chk("flush_done_level", 32'(a_lvl),  32'd0);
    push(1'b0, 8'h51, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("after_flush_data", 32'(a_out), 32'h51);
    chk("after_flush_txv",  32'(a_txv), 32'd1);
    @(negedge clk);
    chk("after_flush_end",  32'(a_txv), 32'd0);

    // Reset in the middle of a stalled packet
    a_txr = 1'b0;
    push(1'b0, 8'h61, 1'b0);
    push(1'b0, 8'h62, 1'b0);
    push(1'b0, 8'h63, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_txv",  32'(a_txv), 32'd1);
    chk("mid_data", 32'(a_out), 32'h61);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_txv",      32'(a_txv),   32'd0);
    chk("mid_rst_in_ready", 32'(a_ready), 32'd0);
    chk("mid_rst_level",    32'(a_lvl),   32'd0);
    chk("mid_rst_busy",     32'(a_busy),  32'd0);
    chk("mid_rst_data",     32'(a_out),   32'd0);
    chk("mid_rst_unr",      32'(a_unr),   32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_in_ready", 32'(a_ready), 32'd1);
    a_txr = 1'b1;
    push(1'b0, 8'h77, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("new_pkt_data", 32'(a_out), 32'h77);
    chk("new_pkt_txv",  32'(a_txv), 32'd1);
    @(negedge clk);
    chk("new_pkt_end_txv",   32'(a_txv), 32'd0);
    chk("new_pkt_end_level", 32'(a_lvl), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
